trng_sample_ctrl: RTL
=====================

TRNG_SAMPLE_CTRL -- requirements
Module: trng_sample_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, meaning debiased bits per output word.
REQ-002 The block SHALL have parameter PRE_CYC, default 2, meaning cycles latch_rst is held high per sample.
REQ-003 The block SHALL have parameter RCT_LIMIT, default 32, meaning consecutive identical raw samples that trip the health test.
REQ-004 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: enable  input  1  run request; low parks the FSM in IDLE.
REQ-007 Port: cfg_settle  input  4  settle length, giving cfg_settle+1 cycles between latch release and sampling.
REQ-008 Port: latch_rst  output  1  precharge/reset drive to the latch entropy cell; 1 = cell held.
REQ-009 Port: latch_bit  input  1  raw resolved value from the latch cell.
REQ-010 Port: word_valid  output  1  word holds a complete debiased word.
REQ-011 Port: word_ready  input  1  consumer accepts word when high with word_valid.
REQ-012 Port: word  output  WORD_W  packed debiased bits; the newest bit is in word[0].
REQ-013 Port: health_fail  output  1  sticky repetition-count failure flag.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, PRECHARGE, SETTLE, SAMPLE, HOLD, FAIL.
REQ-015 IDLE SHALL hold latch_rst=1 and move to PRECHARGE on the first edge where enable=1.
REQ-016 PRECHARGE SHALL hold latch_rst=1 for PRE_CYC cycles, then move to SETTLE.
REQ-017 SETTLE SHALL hold latch_rst=0 for cfg_settle+1 cycles, then move to SAMPLE; cfg_settle is sampled on entry to SETTLE.
REQ-018 SAMPLE SHALL hold latch_rst=0 for 1 cycle, capture latch_bit at that cycle's edge, then move to PRECHARGE.
REQ-019 With cfg_settle=0 and PRE_CYC=2, one raw sample SHALL be taken every 4 cycles.
REQ-020 Raw samples SHALL be debiased as von Neumann pairs (a,b): 01 emits 0; 10 emits 1; 00 and 11 emit nothing.
REQ-021 Each emitted bit SHALL shift into word at LSB, with word[WORD_W-1:1] <= word[WORD_W-2:0].
REQ-022 When the WORD_W-th bit is emitted, SAMPLE SHALL go to HOLD instead of PRECHARGE, and word_valid SHALL be 1 from the next cycle.
REQ-023 In HOLD, latch_rst SHALL be 1, no sampling SHALL occur, and word SHALL be stable.
REQ-024 In HOLD, word_valid&&word_ready SHALL clear word_valid and the bit count on the next edge; the next state is PRECHARGE if enable=1, else IDLE.
REQ-025 HOLD SHALL ignore enable until the handshake completes.
REQ-026 If enable=0 in PRECHARGE, SETTLE or SAMPLE, the next state SHALL be IDLE, the pending half-pair SHALL be discarded, and partial word bits SHALL be kept.
REQ-027 An enable drop in the SAMPLE cycle SHALL still process that sample.
REQ-028 The repetition counter SHALL increment when a captured raw sample equals the previous raw sample, else reload to 1.
REQ-029 The repetition counter SHALL saturate at RCT_LIMIT.
REQ-030 When the repetition counter reaches RCT_LIMIT, health_fail SHALL be 1 from the next cycle and the FSM SHALL enter FAIL.
REQ-031 FAIL SHALL hold latch_rst=1 and word_valid=0, and SHALL be left only by reset.
REQ-032 If the RCT trip and word completion occur on the same sample, the failure SHALL win: the word is discarded and word_valid stays 0.
REQ-033 The debias pair state and the repetition history SHALL survive IDLE, except as REQ-026 states.

Reset
REQ-034 While reset=1 at an edge, the FSM SHALL go to IDLE, with latch_rst=1, word_valid=0, word=0 and health_fail=0.
REQ-035 Reset SHALL also clear the bit count, the half-pair, and the repetition counter (to 0, no previous sample).
REQ-036 Reset SHALL take priority over every other event, including HOLD handshakes and FAIL.

Structure
REQ-037 Package trng_pkg SHALL hold the state enum and the default values of WORD_W, PRE_CYC and RCT_LIMIT.
REQ-038 The von Neumann pair logic SHALL be sub-module trng_vn_debias: inputs sample strobe, raw bit and clear; outputs out_valid and out_bit.
REQ-039 The FSM, phase counter, packer and RCT logic SHALL stay in trng_sample_ctrl.

Verification
REQ-040 Bench SHALL drive enable=1, cfg_settle=0 and constant latch_bit=1 -> latch_rst pattern 1,1,0,0 repeating, and samples at 4-cycle spacing.
REQ-041 Bench SHALL feed raw sequence 0,1,1,0 repeated for 16 pairs with word_ready=1 -> word=16'h5555 with word_valid high for exactly 1 cycle.
REQ-042 Bench SHALL hold word_ready=0 for 20 cycles after word_valid -> word stable, latch_rst=1 and no samples taken; on acceptance, sampling resumes after PRE_CYC cycles.
REQ-043 Bench SHALL feed 32 consecutive raw 0s after reset -> health_fail=1 the cycle after the 32nd sample; further toggling leaves the FSM in FAIL until reset.
REQ-044 Bench SHALL drop enable mid-SETTLE after 1 raw sample -> IDLE next cycle; after re-enable, the half-pair is gone and the kept bit count continues.
REQ-045 Bench SHALL assert reset in HOLD with word_ready=1 -> IDLE, word_valid=0 and word=0.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared FSM state encoding and default parameters for the latch TRNG sampler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trng_pkg;

  localparam int WORD_W_DEF    = 16;
  localparam int PRE_CYC_DEF   = 2;
  localparam int RCT_LIMIT_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    SETTLE,
    SAMPLE,
    HOLD,
    FAIL
  } state_e;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann corrector: pairs raw samples, 01 -> 0, 10 -> 1, 00/11 dropped.
// Latency: out_valid is combinational on the strobe that completes a pair.
// Backpressure: none; the caller strobes only when it can take a bit.
module trng_vn_debias (
  input  logic clk,
  input  logic sample_i,
  input  logic raw_i,
  input  logic clear_i,
  output logic out_valid_o,
  output logic out_bit_o
);

  logic half_vld_q;
  logic half_bit_q;

  // The pair completes on the second strobe; the first sample of the pair is the emitted bit.
  assign out_valid_o = sample_i && half_vld_q && (half_bit_q != raw_i);
  assign out_bit_o   = half_bit_q;

  // Hold the first half of a pair; clear drops any pending half without affecting the current output.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      half_vld_q <= 1'b0;
      half_bit_q <= 1'b0;
    end else if (sample_i) begin
      half_vld_q <= !half_vld_q;
      half_bit_q <= raw_i;
    end
  end

endmodule

// File: rtl/trng_sample_ctrl.sv
// Latch-cell TRNG sequencer: precharge/settle/sample timing, debias, word packing, repetition health test.
// Latency: one raw sample every PRE_CYC+cfg_settle+2 cycles; word_valid rises the cycle after the last bit.
// Backpressure: a completed word parks the FSM in HOLD (cell held, no sampling) until word_ready.
module trng_sample_ctrl
  import trng_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int PRE_CYC   = PRE_CYC_DEF,
  parameter int RCT_LIMIT = RCT_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        cfg_settle,
  output logic              latch_rst,
  input  logic              latch_bit,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word,
  output logic              health_fail
);

  localparam int PH_W  = (PRE_CYC > 16) ? $clog2(PRE_CYC) : 4;
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int RCT_W = $clog2(RCT_LIMIT + 1);

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [3:0]          settle_q, settle_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                word_valid_q, word_valid_d;
  logic                health_fail_q, health_fail_d;
  logic                latch_rst_q, latch_rst_d;
  logic [RCT_W-1:0]    rct_q, rct_d;
  logic                prev_vld_q, prev_vld_d;
  logic                prev_bit_q, prev_bit_d;

  logic sample_stb;
  logic vn_clear;
  logic vn_valid;
  logic vn_bit;
  logic rct_trip;
  logic word_done;

  assign sample_stb = (state_q == SAMPLE);
  // An enable drop while sequencing abandons the half-finished pair.
  assign vn_clear   = reset || (!enable && (state_q == PRECHARGE || state_q == SETTLE || state_q == SAMPLE));

  trng_vn_debias u_debias (
    .clk         (clk),
    .sample_i    (sample_stb),
    .raw_i       (latch_bit),
    .clear_i     (vn_clear),
    .out_valid_o (vn_valid),
    .out_bit_o   (vn_bit)
  );

  // Next-state: health test, bit packer and sequencing FSM; failure outranks word completion.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    settle_d      = settle_q;
    bit_cnt_d     = bit_cnt_q;
    word_d        = word_q;
    word_valid_d  = word_valid_q;
    health_fail_d = health_fail_q;
    rct_d         = rct_q;
    prev_vld_d    = prev_vld_q;
    prev_bit_d    = prev_bit_q;
    rct_trip      = 1'b0;
    word_done     = 1'b0;

    if (sample_stb) begin
      prev_vld_d = 1'b1;
      prev_bit_d = latch_bit;
      if (prev_vld_q && (latch_bit == prev_bit_q)) begin
        if (rct_q != RCT_W'(RCT_LIMIT)) rct_d = rct_q + 1'b1;
      end else begin
        rct_d = RCT_W'(1);
      end
      rct_trip = (rct_d == RCT_W'(RCT_LIMIT));
    end

    if (vn_valid) begin
      word_d    = {word_q[WORD_W-2:0], vn_bit};
      bit_cnt_d = bit_cnt_q + 1'b1;
      word_done = (bit_cnt_q == CNT_W'(WORD_W - 1));
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = PRECHARGE;
          phase_d = '0;
        end
      end
      PRECHARGE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (phase_q == PH_W'(PRE_CYC - 1)) begin
          state_d  = SETTLE;
          phase_d  = '0;
          settle_d = cfg_settle;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SETTLE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (phase_q == PH_W'(settle_q)) begin
          state_d = SAMPLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SAMPLE: begin
        if (rct_trip) begin
          state_d       = FAIL;
          health_fail_d = 1'b1;
          word_valid_d  = 1'b0;
        end else if (word_done) begin
          state_d      = HOLD;
          word_valid_d = 1'b1;
        end else if (!enable) begin
          state_d = IDLE;
        end else begin
          state_d = PRECHARGE;
          phase_d = '0;
        end
      end
      HOLD: begin
        if (word_valid_q && word_ready) begin
          word_valid_d = 1'b0;
          bit_cnt_d    = '0;
          phase_d      = '0;
          state_d      = enable ? PRECHARGE : IDLE;
        end
      end
      FAIL: begin
        word_valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The cell is only released while settling and sampling.
    latch_rst_d = !((state_d == SETTLE) || (state_d == SAMPLE));
  end

  // State and registered outputs; reset outranks every handshake and the failure lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      settle_q      <= '0;
      bit_cnt_q     <= '0;
      word_q        <= '0;
      word_valid_q  <= 1'b0;
      health_fail_q <= 1'b0;
      latch_rst_q   <= 1'b1;
      rct_q         <= '0;
      prev_vld_q    <= 1'b0;
      prev_bit_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      settle_q      <= settle_d;
      bit_cnt_q     <= bit_cnt_d;
      word_q        <= word_d;
      word_valid_q  <= word_valid_d;
      health_fail_q <= health_fail_d;
      latch_rst_q   <= latch_rst_d;
      rct_q         <= rct_d;
      prev_vld_q    <= prev_vld_d;
      prev_bit_q    <= prev_bit_d;
    end
  end

  assign latch_rst   = latch_rst_q;
  assign word_valid  = word_valid_q;
  assign word        = word_q;
  assign health_fail = health_fail_q;

endmodule
